vga_scan_ctrl: RTL
==================

// Module: vga_scan_ctrl
// PURPOSE
// - VGA 640x480@60 scan generator and pixel compositor; the source end of the row_addr/col_addr/px interface used by the game layers (ground, dino, obstacles).
// - Drives row_addr/col_addr/fresh to every layer, collects each layer's 1-bit px, and resolves priority to 12-bit RGB.
// - Delays hsync/vsync/blank to align with the layers' registered px.
// PARAMETERS
// H_ACTIVE  640  visible pixels per line
// H_FP      16   horizontal front porch
// H_SYNC    96   hsync pulse width
// H_BP      48   horizontal back porch (line total 800)
// V_ACTIVE  480  visible lines per frame
// V_FP      10   vertical front porch
// V_SYNC    2    vsync pulse width
// V_BP      33   vertical back porch (frame total 525)
// LAYERS    4    number of px layer inputs; bit 0 is highest priority
// PX_LAT    1    cycles from row_addr/col_addr to valid px (1..4)
// COLORS    LAYERS*12 bits, default {12'h000,12'h0F0,12'hF00,12'h555}; layer i colour = COLORS[12*i+:12]
// BG        12'hFFF  background colour
// PORTS
// clk       in   1        pixel clock, 25 MHz (clkdiv[1] at top level)
// rst       in   1        synchronous reset, active-high
// px        in   LAYERS   per-layer pixel-on flags, valid PX_LAT cycles after address
// row_addr  out  9        current line 0..479; 9'h1FF during vertical blanking
// col_addr  out  10       current horizontal count 0..799
// fresh     out  1        1 during active lines; falls on entry to vertical blanking
// hs        out  1        hsync, active-low
// vs        out  1        vsync, active-low
// rdn       out  1        blank, active-low: 0 = visible pixel
// rgb       out  12       {r[3:0],g[3:0],b[3:0]}; 0 when blanked
// BEHAVIOUR
// - Reset: h_cnt=0, v_cnt=0, row_addr=0, col_addr=0, fresh=1; hs=1, vs=1, rdn=1, rgb=0.
// - Reset also flushes the alignment pipeline to blank/no-sync; a reset mid-frame restarts at (0,0) on the next cycle.
// - h_cnt increments every clk and wraps 799->0. v_cnt increments when h_cnt wraps, and wraps 524->0.
// - col_addr = h_cnt.
// - row_addr = v_cnt[8:0] when v_cnt<480, else 9'h1FF. 511 must stay outside every layer's draw band.
// - fresh = (v_cnt<480). It falls exactly once per frame, at h_cnt=0 of line 480, so layer state updates run on negedge fresh during blanking.
// - Raw timing at count (h,v):
//   - visible = h<640 && v<480
//   - hs_raw = !(656<=h<752)
//   - vs_raw = !(490<=v<492)
// - Alignment: visible/hs_raw/vs_raw pass through a PX_LAT-deep shift register, then one output register.
//   - The address presented at cycle t produces rdn/hs/vs/rgb at t+PX_LAT+1.
// - Compositor, registered: if !visible_d, rgb=0. Otherwise rgb = colour of the lowest-index set px bit, or BG if px==0.
// - px is sampled only at the matching delayed position. px during blanking is ignored.
// - All counter arithmetic is unsigned; no saturation; no state machine beyond the two wrapping counters.
// TESTING
// - Release rst, run 800*525 clocks -> exactly 1 fresh falling edge, at count (0,480); h/v counts return to (0,0).
// - Per line, PX_LAT=1 -> hs low 96 clocks. The first hs=0 comes 2 cycles after col_addr=656. rdn=0 for 640 clocks per visible line.
// - Per frame -> vs low for exactly 2*800 clocks, starting 2 cycles after row count 490, h=0. rdn stays 1 throughout lines 480..524.
// - Drive px=4'b0110 on the visible pixel (10,400) -> rgb=12'h0F0 (layer1 wins) 2 cycles after that address; px=0 -> 12'hFFF; blanked -> 12'h000.
// - Check row_addr: 9'h1FF for all of lines 480..524; 0 at line 0; 479 on the last visible line.
// - Assert rst at count (300,200) for 1 clock -> next cycle col_addr=0, row_addr=0, hs=vs=rdn=1, rgb=0. Normal timing resumes with no stale pipeline pixels.

Source files
------------

// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl - VGA scan generator and pixel compositor.
//
// The two wrapping counters (h_q and v_q) drive the row_addr, col_addr and
// fresh outputs to every layer. The design collects one px bit per layer and
// resolves the bits by priority into 12-bit RGB. The raw visible, hsync and
// vsync signals are delayed so that they line up with the layers' registered
// px.
//
// Ports
//   clk_i       pixel clock
//   rst_i       synchronous reset, active-high
//   px_i        per-layer pixel-on flags, valid PX_LAT cycles after address
//   row_addr_o  current line, 9'h1FF during vertical blanking
//   col_addr_o  current horizontal count
//   fresh_o     1 during active lines, falls on entry to vertical blanking
//   hs_o/vs_o   syncs, active-low
//   rdn_o       blank, active-low (0 = visible pixel)
//   rgb_o       {r,g,b} 4 bits each, 0 when blanked
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int LAYERS   = 4,
  parameter int PX_LAT   = 1,
  // Layer i colour is COLORS[12*i+:12]. With the default value, layer 0 is
  // 000, layer 1 is 0F0, layer 2 is F00 and layer 3 is 555.
  parameter logic [LAYERS*12-1:0] COLORS = {12'h555, 12'hF00, 12'h0F0, 12'h000},
  parameter logic [11:0]          BG     = 12'hFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LAYERS-1:0] px_i,
  output logic [8:0]        row_addr_o,
  output logic [9:0]        col_addr_o,
  output logic              fresh_o,
  output logic              hs_o,
  output logic              vs_o,
  output logic              rdn_o,
  output logic [11:0]       rgb_o
);

  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
  } tm_t;

  localparam tm_t TM_IDLE = '{vis: 1'b0, hs: 1'b1, vs: 1'b1};

  logic [9:0] h_q, h_d, v_q, v_d;

  // Stage 0 is the raw timing at the current count. Stage k is that timing
  // k cycles later. tm_q holds stages 1..PX_LAT.
  tm_t [PX_LAT-1:0] tm_q;
  tm_t [PX_LAT:0]   tm_pipe;
  tm_t              tm_raw;

  logic        hs_q, vs_q, rdn_q;
  logic [11:0] rgb_q, rgb_d;

  // Counter next state
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  always_comb begin
    tm_raw.vis = (h_q < H_VIS) && (v_q < V_VIS);
    tm_raw.hs  = !((h_q >= HS_START) && (h_q < HS_END));
    tm_raw.vs  = !((v_q >= VS_START) && (v_q < VS_END));
  end

  assign tm_pipe = {tm_q, tm_raw};

  // Priority compositor. The loop runs from the highest index down, so the
  // lowest set bit is written last and wins. Blanking overrides any px.
  always_comb begin
    rgb_d = BG;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (px_i[i]) rgb_d = COLORS[12*i +: 12];
    end
    if (!tm_pipe[PX_LAT].vis) rgb_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q   <= '0;
      v_q   <= '0;
      tm_q  <= {PX_LAT{TM_IDLE}};
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rdn_q <= 1'b1;
      rgb_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      tm_q  <= tm_pipe[PX_LAT-1:0];
      hs_q  <= tm_pipe[PX_LAT].hs;
      vs_q  <= tm_pipe[PX_LAT].vs;
      rdn_q <= !tm_pipe[PX_LAT].vis;
      rgb_q <= rgb_d;
    end
  end

  assign col_addr_o = h_q;
  // 9'h1FF lies outside every layer's draw band, so the layers draw nothing
  // during vertical blanking.
  assign row_addr_o = (v_q < V_VIS) ? v_q[8:0] : 9'h1FF;
  assign fresh_o    = (v_q < V_VIS);
  assign hs_o       = hs_q;
  assign vs_o       = vs_q;
  assign rdn_o      = rdn_q;
  assign rgb_o      = rgb_q;

endmodule
